// File: rtl/mips_pkg.sv
// Shared widths and dump FSM state encoding for the MIPS register file slice.
package mips_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } dump_state_t;
endpackage

// File: rtl/reg_file_dump_fsm.sv
// Dump sequencer: walks indices 0..NUM_REGS-1, one beat per valid/ready handshake.
// Each stalled cycle holds the beat; it requests a snapshot load when a new beat starts.
module reg_file_dump_fsm
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dump_start,
   input  logic              dump_ready,
   output logic              dump_valid,
   output logic              dump_busy,
   output logic              dump_done,
   output logic [ADDR_W-1:0] dump_addr,
   output logic              load_vld,
   output logic [ADDR_W-1:0] load_idx
);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   dump_state_t       state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // The load strobe fires on the same edge the index advances, so the
   // snapshot always matches the index being presented.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      load_vld = 1'b0;
      load_idx = idx_q;
      case (state_q)
         IDLE: begin
            if (dump_start) begin
               state_d  = SCAN;
               idx_d    = '0;
               load_vld = 1'b1;
               load_idx = '0;
            end
         end
         SCAN: begin
            if (dump_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d    = idx_q + 1'b1;
                  load_vld = 1'b1;
                  load_idx = idx_q + 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dump_valid = (state_q == SCAN);
      dump_busy  = (state_q == SCAN);
      dump_done  = (state_q == DONE);
      dump_addr  = idx_q;
   end
endmodule

// File: rtl/mips_reg_file.sv
// 32x32 register file: 2 combinational read ports, 1 write port (1-edge latency), r0 hardwired 0.
// Debug dump streams a registered snapshot per beat; a stalled beat holds even if its register is rewritten.
module mips_reg_file
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   input  logic              WE3,
   input  logic [ADDR_W-1:0] A3,
   input  logic [DATA_W-1:0] WD3,
   input  logic              dump_start,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_busy,
   output logic              dump_done
);
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] dump_data_q;
   logic              load_vld;
   logic [ADDR_W-1:0] load_idx;

   reg_file_dump_fsm u_dump_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .dump_start (dump_start),
      .dump_ready (dump_ready),
      .dump_valid (dump_valid),
      .dump_busy  (dump_busy),
      .dump_done  (dump_done),
      .dump_addr  (dump_addr),
      .load_vld   (load_vld),
      .load_idx   (load_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (WE3 && (A3 != '0)) begin
         regs[A3] <= WD3;
      end
   end

   // No write-to-read bypass: a bypass would loop back through the ALU.
   assign RD1 = (A1 == '0) ? '0 : regs[A1];
   assign RD2 = (A2 == '0) ? '0 : regs[A2];

   // Reads the pre-edge array, so a coincident write to load_idx is not seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dump_data_q <= '0;
      end else if (load_vld) begin
         dump_data_q <= (load_idx == '0) ? '0 : regs[load_idx];
      end
   end

   assign dump_data = dump_data_q;
endmodule

// File: tb/tb_mips_reg_file.sv
// Bench for mips_reg_file: vector table for read/write rules, randomized traffic and dumps vs an array model.
module tb_mips_reg_file;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  A1, A2, A3;
   logic [31:0] RD1, RD2, WD3;
   logic        WE3;
   logic        dump_start, dump_valid, dump_ready, dump_busy, dump_done;
   logic [4:0]  dump_addr;
   logic [31:0] dump_data;

   int checks = 0;
   int errors = 0;
   logic [31:0] mregs [32];

   typedef struct {
      logic        we;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] pre1;
      logic [31:0] pre2;
      logic [31:0] post1;
      logic [31:0] post2;
   } vec_t;
   vec_t vecs [6];

   mips_reg_file dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .A1         (A1),
      .A2         (A2),
      .RD1        (RD1),
      .RD2        (RD2),
      .WE3        (WE3),
      .A3         (A3),
      .WD3        (WD3),
      .dump_start (dump_start),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data),
      .dump_busy  (dump_busy),
      .dump_done  (dump_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : mregs[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
   endtask

   // One clock: the model applies the write the DUT sees at this edge.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_clear();
      else if (WE3 && A3 != 5'd0) mregs[A3] = WD3;
      #1;
   endtask

   task automatic run_dump(input int stall_pct, input int wr_pct, input int stop_at);
      int          exp_idx;
      int          cycles;
      logic [31:0] exp_snap;
      logic [31:0] nxt;
      bit          fin;
      logic        acc;
      chk("idle_busy", dump_busy, 0);
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      exp_idx  = 0;
      exp_snap = 32'd0;
      nxt      = 32'd0;
      cycles   = 0;
      fin      = 1'b0;
      while (!fin && cycles < 400) begin
         if (stop_at >= 0 && exp_idx == stop_at) begin
            rst_n = 1'b0;
            model_clear();
            #1;
            chk("rst_valid", dump_valid, 0);
            chk("rst_busy", dump_busy, 0);
            chk("rst_done", dump_done, 0);
            chk("rst_addr", dump_addr, 0);
            chk("rst_data", dump_data, 0);
            dump_ready = 1'b1;
            repeat (3) begin
               tick();
               chk("rst_hold_done", dump_done, 0);
               chk("rst_hold_valid", dump_valid, 0);
            end
            rst_n = 1'b1;
            tick();
            chk("post_rst_done", dump_done, 0);
            for (int a = 0; a < 32; a++) begin
               A1 = 5'(a);
               A2 = 5'(31 - a);
               #1;
               chk("post_rst_rd1", RD1, 0);
               chk("post_rst_rd2", RD2, 0);
            end
            return;
         end
         acc = ($urandom_range(99) >= stall_pct);
         dump_ready = acc;
         WE3 = 1'b0;
         if (!acc && $urandom_range(1) == 1) begin
            WE3 = 1'b1;
            A3  = 5'(exp_idx);
            WD3 = $urandom;
         end else if ($urandom_range(99) < wr_pct) begin
            WE3 = 1'b1;
            A3  = 5'($urandom_range(31));
            WD3 = $urandom;
         end
         A1 = 5'($urandom_range(31));
         #1;
         chk("beat_valid", dump_valid, 1);
         chk("beat_busy", dump_busy, 1);
         chk("beat_done", dump_done, 0);
         chk("beat_addr", dump_addr, 32'(exp_idx));
         chk("beat_data", dump_data, exp_snap);
         chk("dump_rd1", RD1, model_rd(A1));
         if (acc) begin
            if (exp_idx == 31) fin = 1'b1;
            else nxt = mregs[exp_idx + 1];
         end
         cycles++;
         tick();
         if (acc && !fin) begin
            exp_idx++;
            exp_snap = nxt;
         end
      end
      WE3 = 1'b0;
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL dump_timeout: beats_left %0d required 0", 32 - exp_idx);
      end
      chk("end_done", dump_done, 1);
      chk("end_valid", dump_valid, 0);
      chk("end_busy", dump_busy, 0);
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      chk("after_done", dump_done, 0);
      chk("start_in_done_ignored", dump_busy, 0);
      chk("after_valid", dump_valid, 0);
   endtask

   initial begin
      vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd31, 32'h0,  32'h0,        32'hDEADBEEF, 32'h0};
      vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
      vecs[2] = '{1'b0, 5'd7,  32'hFFFFFFFF, 5'd7,  5'd0,  32'h0,  32'h0,        32'h0,        32'h0};
      vecs[3] = '{1'b1, 5'd9,  32'h00000011, 5'd9,  5'd7,  32'h0,  32'h0,        32'h11,       32'h0};
      vecs[4] = '{1'b1, 5'd9,  32'h00000022, 5'd9,  5'd5,  32'h11, 32'hDEADBEEF, 32'h22,       32'hDEADBEEF};
      vecs[5] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd9,  32'h0,  32'h22,       32'hA5A5A5A5, 32'h22};

      rst_n = 1'b0;
      A1 = 5'd5; A2 = 5'd31; A3 = 5'd0; WD3 = 32'd0; WE3 = 1'b0;
      dump_start = 1'b0; dump_ready = 1'b0;
      model_clear();
      tick();
      tick();
      chk("reset_valid", dump_valid, 0);
      chk("reset_busy", dump_busy, 0);
      chk("reset_done", dump_done, 0);
      chk("reset_addr", dump_addr, 0);
      chk("reset_data", dump_data, 0);
      chk("reset_rd1", RD1, 0);
      chk("reset_rd2", RD2, 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         WE3 = vecs[i].we; A3 = vecs[i].a3; WD3 = vecs[i].wd;
         A1 = vecs[i].a1; A2 = vecs[i].a2;
         #1;
         chk("vec_pre_rd1", RD1, vecs[i].pre1);
         chk("vec_pre_rd2", RD2, vecs[i].pre2);
         tick();
         chk("vec_post_rd1", RD1, vecs[i].post1);
         chk("vec_post_rd2", RD2, vecs[i].post2);
      end
      WE3 = 1'b0;

      for (int i = 0; i < 60; i++) begin
         WE3 = $urandom_range(1) == 1;
         A3  = 5'($urandom_range(31));
         WD3 = $urandom;
         A1  = ($urandom_range(3) == 0) ? A3 : 5'($urandom_range(31));
         A2  = 5'($urandom_range(31));
         #1;
         chk("rand_rd1", RD1, model_rd(A1));
         chk("rand_rd2", RD2, model_rd(A2));
         tick();
      end

      for (int i = 1; i < 32; i++) begin
         WE3 = 1'b1; A3 = 5'(i); WD3 = 32'(i * 256);
         tick();
      end
      WE3 = 1'b0;
      A2 = 5'd31;
      #1;
      chk("preload_r31", RD2, 32'h1F00);

      run_dump(0, 0, -1);
      run_dump(40, 20, -1);
      run_dump(0, 0, -1);
      run_dump(0, 0, 10);
      run_dump(0, 0, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mips_reg_file.md
# mips_reg_file

Architectural register file for the single-cycle MIPS datapath. It is the consumer of the destination-register select: it takes the write address chosen by the A3 mux, with write data and write enable, and serves the two combinational source-operand read ports (rs/rt). It also contains a handshaked debug dump engine that streams all 32 registers out one per beat for testbench and board-level state inspection.

## Interface
- DATA_W, 32, register and data width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- A1  in  ADDR_W  read address 1 (instr[25:21]).
- A2  in  ADDR_W  read address 2 (instr[20:16]).
- RD1  out  DATA_W  read data 1, combinational.
- RD2  out  DATA_W  read data 2, combinational.
- WE3  in  1  write enable (RegWrite).
- A3  in  ADDR_W  write address, driven by the A3 mux output.
- WD3  in  DATA_W  write data (ALU result or memory load data).
- dump_start  in  1  starts a register dump; honoured only in IDLE.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  consumer accepts the beat.
- dump_addr  out  ADDR_W  register index of the current beat.
- dump_data  out  DATA_W  register contents of the current beat.
- dump_busy  out  1  high in SCAN.
- dump_done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- Storage: NUM_REGS x DATA_W flops. Reset clears every register to 0.
- Write: on the rising clk edge, when WE3=1 and A3!=0, regs[A3] <= WD3. Writes to A3=0 are discarded.
- Read: RDn = (An==0) ? 0 : regs[An]. No write-to-read bypass. A same-cycle write is visible only after the edge. A bypass would close a combinational loop through the ALU in a single-cycle datapath.
- Dump FSM states: IDLE, SCAN, DONE.
  - IDLE: when dump_start=1, go to SCAN; idx<=0; load the beat.
  - SCAN: dump_valid=1. On dump_valid&&dump_ready: if idx==NUM_REGS-1, go to DONE; otherwise idx<=idx+1 and load the next beat.
  - DONE: dump_done=1 for one cycle, then go to IDLE.
- Beat load: dump_data<=regs[next idx], with entry 0 forced to 0. The value is a registered snapshot that stays stable while dump_valid&&!dump_ready, even if that register is written in the meantime.
- A write on the same edge as a beat load to the same index loads the pre-write value.
- dump_start is ignored in SCAN and DONE. Dumping never blocks or delays architectural reads or writes.
- dump_addr=idx. idx does not wrap during a dump; the FSM exits after index 31.

## Timing
- Reset values: dump_valid=0, dump_busy=0, dump_done=0, dump_addr=0, dump_data=0, state=IDLE, all registers 0. RD1/RD2 follow the cleared array, so they read 0.
- Read latency 0 (combinational). Write latency 1 edge.
- Dump: dump_start sampled at edge N gives dump_valid=1 with addr 0 from edge N. With dump_ready held high, beats occupy cycles N..N+31 and dump_done is high in cycle N+32. Back-to-back start is possible from cycle N+33.
- Each stall cycle (dump_ready=0) extends the dump by exactly one cycle.
- Reset asserted mid-dump: immediately IDLE, outputs at reset values, registers cleared. No dump_done.

## Structure
- Shared package mips_pkg: DATA_W, ADDR_W, NUM_REGS constants; dump_state_t enum {IDLE, SCAN, DONE}.
- One sub-module: reg_file_dump_fsm. It owns state, idx, the handshake and dump_done; it drives the beat-load strobe and index to the top, which holds the array and the dump_data snapshot register.

## Test plan
- Reset then read A1=5, A2=31: RD1=0, RD2=0. Write WE3=1, A3=5, WD3=0xDEADBEEF; before the edge RD1=0, after the edge RD1=0xDEADBEEF.
- WE3=1, A3=0, WD3=0xFFFFFFFF, then A1=0: RD1=0 always. Same data with WE3=0 and A3=7: regs[7] unchanged.
- Same-cycle A1=A3=9, old value 0x11, WD3=0x22: RD1=0x11 until the edge, then 0x22.
- Preload regs[i]=i*0x100, dump_start with dump_ready=1: 32 beats with addr 0..31, data 0, 0x100, ... 0x1F00. dump_done pulses exactly once, 32 cycles after the start beat.
- Random dump_ready stalls, with a write to the presented index during a stall: dump_data holds the snapshot, no beat is lost or duplicated, and the next dump shows the new value.
- rst_n low at beat 10: dump_valid=0 and dump_busy=0 immediately, no dump_done, all registers read 0. A new dump_start afterwards begins at addr 0.
